// File: rtl/sram_pkg.sv
// Shared types for the async SRAM arbiter.
// State encoding and strobe levels.
package sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  // SRAM control pins are active-low.
  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from N requests.
// Ports: clk, rst, req[N], take (grant used), gnt[N].
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         take,
  output logic [N-1:0] gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] j;
  logic          found;

  // Scan from ptr_q upward, wrapping; first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_q) + i) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (take && found) begin
      if (idx == IW'(N - 1)) ptr_q <= '0;
      else                   ptr_q <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// N-channel round-robin controller for one async SRAM.
// Ports: req/we/addr/wdata in, gnt/rvalid/rdata/busy out, SRAM pins.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int N_CH     = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          we,
  input  logic [N_CH*ADDR_W-1:0]   addr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  output logic [N_CH-1:0]          gnt,
  output logic [N_CH-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  inout  wire  [DATA_W-1:0]        sram_data,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic                     sram_en,
  output logic                     sram_oe,
  output logic                     sram_we
);

  localparam int CW =
    (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                wr_q;
  logic [N_CH-1:0]     own_q;

  logic [N_CH-1:0]     arb_gnt;
  logic                take;
  logic                drive;
  logic                last;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .take (take),
    .gnt  (arb_gnt)
  );

  // Mux the winning channel's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_we    = we[i];
      end
    end
  end

  assign last = (cnt_q == CW'(WAIT_CYC));

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    rvalid  = '0;
    take    = 1'b0;
    drive   = 1'b0;
    sram_en = STB_OFF;
    sram_oe = STB_OFF;
    sram_we = STB_OFF;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt     = arb_gnt;
          take    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        sram_en = STB_ON;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        sram_en = STB_ON;
        sram_oe = wr_q ? STB_OFF : STB_ON;
        sram_we = wr_q ? STB_ON : STB_OFF;
        drive   = wr_q;
        if (last) state_d = S_HOLD;
      end
      S_HOLD: begin
        sram_en = STB_ON;
        drive   = wr_q;
        rvalid  = wr_q ? '0 : own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wr_q    <= sel_we;
        own_q   <= arb_gnt;
      end
      if (state_q == S_STROBE) begin
        if (last) begin
          cnt_q <= '0;
          // Capture on the edge that ends the strobe.
          if (!wr_q) rdata_q <= sram_data;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign sram_data = drive ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a tiny SRAM model.
// Second instance covers N_CH=4, WAIT_CYC=0 arbitration.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [35:0] addr;
  logic [31:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        busy;
  wire  [15:0] sram_data;
  logic [17:0] sram_addr;
  logic        sram_en, sram_oe, sram_we;

  logic [3:0]  req2, we2;
  logic [71:0] addr2;
  logic [63:0] wdata2;
  logic [3:0]  gnt2, rvalid2;
  logic [15:0] rdata2;
  logic        busy2;
  wire  [15:0] sram_data2;
  logic [17:0] sram_addr2;
  logic        en2, oe2, swe2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(
    .DATA_W(16), .ADDR_W(18), .N_CH(2), .WAIT_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_en(sram_en), .sram_oe(sram_oe),
    .sram_we(sram_we)
  );

  sram_arbiter #(
    .DATA_W(16), .ADDR_W(18), .N_CH(4), .WAIT_CYC(0)
  ) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2),
    .addr(addr2), .wdata(wdata2), .gnt(gnt2),
    .rvalid(rvalid2), .rdata(rdata2), .busy(busy2),
    .sram_data(sram_data2), .sram_addr(sram_addr2),
    .sram_en(en2), .sram_oe(oe2), .sram_we(swe2)
  );

  // Undriven bus reads as 0, so any stray drive shows up.
  for (genvar b = 0; b < 16; b++) begin : g_pd
    pulldown pd1 (sram_data[b]);
    pulldown pd2 (sram_data2[b]);
  end

  // SRAM model: 16 words indexed by addr[3:0].
  logic [15:0] mem [16];
  logic [15:0] mdl_q;

  always_comb mdl_q = mem[sram_addr[3:0]];

  assign sram_data =
    (!sram_en && !sram_oe) ? mdl_q : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
      mem[0] <= 16'hBEEF;
    end else if (!sram_en && !sram_we) begin
      mem[sram_addr[3:0]] <= sram_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One access on dut: request, wait grant, trace 5 cycles.
  task automatic access(input int          ch,
                        input bit          wr,
                        input logic [17:0] a,
                        input logic [15:0] d,
                        input logic [15:0] exp_rd);
    int n;
    @(posedge clk); #1;
    req = '0;
    if (ch == 0) begin
      req[0] = 1'b1; we[0] = wr;
      addr[17:0] = a; wdata[15:0] = d;
    end else begin
      req[1] = 1'b1; we[1] = wr;
      addr[35:18] = a; wdata[31:16] = d;
    end
    n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("acc_gnt", 32'(gnt), 32'(1) << ch);
    @(posedge clk); #1;
    req = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("acc_gnt_busy", 32'(gnt), 32'h0);
      if (c == 1) begin
        chk("setup_ctl", {sram_en, sram_oe, sram_we, busy},
            4'b0111);
        chk("setup_addr", 32'(sram_addr), 32'(a));
        chk("setup_bus", 32'(sram_data), 32'h0);
      end else if (c <= 3) begin
        chk("strobe_ctl", {sram_en, sram_oe, sram_we, busy},
            wr ? 4'b0101 : 4'b0011);
        chk("strobe_bus", 32'(sram_data),
            wr ? 32'(d) : 32'(exp_rd));
        chk("strobe_rv", 32'(rvalid), 32'h0);
      end else if (c == 4) begin
        chk("hold_ctl", {sram_en, sram_oe, sram_we, busy},
            4'b0111);
        chk("hold_bus", 32'(sram_data),
            wr ? 32'(d) : 32'h0);
        chk("hold_rv", 32'(rvalid),
            wr ? 32'h0 : (32'(1) << ch));
        chk("hold_rdata", 32'(rdata), 32'(exp_rd));
      end else begin
        chk("idle_ctl", {sram_en, sram_oe, sram_we, busy},
            4'b1110);
        chk("idle_rv", 32'(rvalid), 32'h0);
        chk("idle_bus", 32'(sram_data), 32'h0);
      end
    end
  endtask

  initial begin
    int last_k;
    int gi;
    logic [1:0] exp_g;
    logic [3:0] exp2 [2];

    rst = 1'b1; req = '0; we = '0;
    addr = '0; wdata = '0;
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {sram_en, sram_oe, sram_we, busy},
        4'b1110);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rv", 32'(rvalid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_bus", 32'(sram_data), 32'h0);
    chk("rst_gnt2", 32'(gnt2), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    access(0, 1'b0, 18'h00010, 16'h0000, 16'hBEEF);
    access(1, 1'b1, 18'h3FFFF, 16'h1234, 16'hBEEF);
    chk("mem_wr", 32'(mem[15]), 32'h1234);
    access(1, 1'b0, 18'h3FFFF, 16'h0000, 16'h1234);

    // Both channels requesting continuously.
    @(posedge clk); #1;
    req = 2'b11; we = 2'b00;
    addr = {18'h00001, 18'h00002};
    exp_g  = 2'b01;
    last_k = -1;
    gi     = 0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        chk("rr_onehot", 32'($countones(gnt)), 32'd1);
        chk("rr_order", 32'(gnt), 32'(exp_g));
        if (last_k >= 0)
          chk("rr_space", 32'(k - last_k), 32'd5);
        last_k = k;
        exp_g  = ~exp_g;
        gi++;
      end
    end
    chk("rr_count", 32'(gi), 32'd4);
    @(posedge clk); #1;
    req = '0;
    repeat (6) @(negedge clk);

    // Reset in the middle of a read strobe.
    @(posedge clk); #1;
    req = 2'b01; we = 2'b00; addr[17:0] = 18'h00010;
    @(negedge clk);
    chk("mr_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_strobe_oe", 32'(sram_oe), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b11;
    @(negedge clk);
    chk("mr_ctl", {sram_en, sram_oe, sram_we, busy},
        4'b1110);
    chk("mr_rv", 32'(rvalid), 32'h0);
    chk("mr_bus", 32'(sram_data), 32'h0);
    chk("mr_gnt_ch0", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    req = '0;
    repeat (6) @(negedge clk);

    // Four channels, no wait cycles.
    @(posedge clk); #1;
    req2 = 4'b0010;
    @(negedge clk);
    chk("n4_first", 32'(gnt2), 32'h2);
    @(posedge clk); #1;
    req2 = 4'b1010;
    exp2[0] = 4'b1000;
    exp2[1] = 4'b0010;
    gi     = 0;
    last_k = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (gnt2 != '0) begin
        if (gi < 2)
          chk("n4_order", 32'(gnt2), 32'(exp2[gi]));
        chk("n4_space", 32'(k - last_k), 32'd4);
        last_k = k;
        gi++;
      end
    end
    chk("n4_count", 32'(gi), 32'd2);
    @(posedge clk); #1;
    req2 = '0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised multi-channel controller for one external asynchronous SRAM (active-low en/oe/we, bidirectional data). It grants up to N_CH requesters round-robin, sequences each access through setup/strobe/hold phases with a configurable number of wait cycles, and returns read data with a per-channel valid pulse. It sits between the CPU-side memory clients (instruction fetch, data access, DMA/UART) and a physical RAM bank, replacing the single-client, fixed-timing SRAM wrapper.

## Interface
- DATA_W, 16, SRAM data width
- ADDR_W, 18, SRAM address width
- N_CH, 2, number of requesting channels (≥1)
- WAIT_CYC, 1, extra strobe cycles beyond the first (≥0)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  N_CH  per-channel access request, held until granted
- we  in  N_CH  per-channel 1 = write, 0 = read
- addr  in  N_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_CH*DATA_W  per-channel write data, same packing
- gnt  out  N_CH  one-hot, one-cycle pulse: request accepted this cycle
- rvalid  out  N_CH  one-hot, one-cycle pulse: rdata valid for that channel
- rdata  out  DATA_W  registered read data, shared by all channels
- busy  out  1  high in every non-IDLE state
- sram_data  inout  DATA_W  SRAM data bus
- sram_addr  out  ADDR_W  SRAM address
- sram_en, sram_oe, sram_we  out  1 each  SRAM chip enable / output enable / write enable, active-low

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any req, arbiter picks channel k (round-robin); gnt[k]=1 combinationally this cycle; at the edge, latch addr/we/wdata of k and owner id, go SETUP. No req: stay IDLE.
- Round-robin: priority starts at (last granted + 1) mod N_CH; after reset, channel 0 highest. Pointer updates only on grant.
- SETUP (1 cycle): sram_addr = latched addr, sram_en=0, oe=1, we=1, data bus Hi-Z.
- STROBE (WAIT_CYC+1 cycles, counted by wait counter): read: oe=0; write: we=0 and sram_data driven with latched wdata.
- HOLD (1 cycle): oe=1, we=1, en=0, address held; write keeps driving data (hold time); read: rvalid[owner]=1, rdata = value sampled from sram_data at the edge ending the last STROBE cycle. Then IDLE.
- sram_data is driven only in STROBE and HOLD of a write; Hi-Z otherwise.
- rdata holds its value until the next read completes; writes do not alter it.
- Requester must keep req/we/addr/wdata stable until the cycle gnt is seen; deasserting req before grant withdraws it with no side effect.
- N_CH=1: arbiter degenerates to pass-through; WAIT_CYC=0: STROBE lasts exactly 1 cycle.

## Timing
- Reset values: sram_en=sram_oe=sram_we=1, sram_data Hi-Z, sram_addr=0, gnt=0, rvalid=0, rdata=0, busy=0, state IDLE, RR pointer → channel 0, wait counter 0.
- Grant at cycle 0 (IDLE) → SETUP cycle 1 → STROBE cycles 2..2+WAIT_CYC → HOLD cycle 3+WAIT_CYC → IDLE cycle 4+WAIT_CYC.
- Read latency: rvalid at cycle 3+WAIT_CYC after grant (4 with default). Access period: WAIT_CYC+4 cycles; earliest next gnt at cycle 4+WAIT_CYC.
- gnt never asserted outside IDLE; requests arriving while busy wait.
- Simultaneous requests: exactly one gnt bit; others retained and served in RR order.
- Reset mid-access: all strobes deassert and bus goes Hi-Z at the reset edge; the access is abandoned, no rvalid; pointer returns to channel 0.

## Structure
- Shared package sram_pkg: state encoding (IDLE/SETUP/STROBE/HOLD), strobe active/inactive level constants.
- Wait counter width max(1, clog2(WAIT_CYC+1)).
- One sub-module: rr_arbiter (N_CH requests, pointer, one-hot grant, update-on-grant input).

## Test plan
- Single read, ch0, addr 0x00010, SRAM model returns 0xBEEF, WAIT_CYC=1 -> gnt[0] cycle 0, oe low cycles 2–3, rvalid[0] cycle 4 with rdata=0xBEEF.
- Write ch1 addr 0x3FFFF data 0x1234 -> we low exactly WAIT_CYC+1 cycles, data driven cycles 2–4, model holds 0x1234; readback returns 0x1234.
- req=2'b11 held continuously, N_CH=2 -> grants alternate ch0, ch1, ch0… spaced 5 cycles apart; never two gnt bits at once.
- N_CH=4, WAIT_CYC=0, req=4'b1010 after last grant to ch1 -> next gnt ch3, then ch1; access period 4 cycles.
- rst asserted in STROBE of a read -> next cycle en/oe/we=1, bus Hi-Z, no rvalid, busy=0; subsequent req=2'b11 grants ch0 first.
- Read after write on same channel -> sram_data never driven by block in SETUP of the read (bus contention checker silent).
